// File: rtl/eight_bit_divider_pkg.sv
// Shared types and constants for the eight_bit_divider slice.
// FSM state encoding, iteration count and the default divide-by-zero quotient.
package eight_bit_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int         DIV_ITER       = 8;
  localparam logic [7:0] DIV0_Q_DEFAULT = 8'hFF;

endpackage

// File: rtl/eight_bit_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module eight_bit_divider_div_step (
  input  logic [7:0] r,
  input  logic       a_msb,
  input  logic [7:0] b,
  output logic [7:0] r_next,
  output logic       ge
);

  logic [8:0] r9;
  logic [8:0] d;

  assign r9 = {r, a_msb};

  eight_bit_suber u_suber (
    .a    (r9[7:0]),
    .b    (b),
    .diff (d)
  );

  // r9[8] set means r9 >= 256 > b, so the subtraction always succeeds.
  assign ge     = r9[8] | d[8];
  assign r_next = ge ? d[7:0] : r9[7:0];

endmodule

// File: rtl/eight_bit_suber.sv
// 8-bit subtractor: diff = a - b with diff[8] set when no borrow occurs (a >= b).
module eight_bit_suber (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] diff
);

  // Two's-complement add; the carry out doubles as the no-borrow flag.
  assign diff = {1'b0, a} + {1'b0, ~b} + 9'd1;

endmodule

// File: rtl/eight_bit_divider.sv
// Sequential 8-bit unsigned restoring divider with start/done handshake.
// Optional EIGHT_BIT_DIVIDER_EARLY_EXIT_EN: finish in one cycle when in_a < in_b.
module eight_bit_divider
  import eight_bit_divider_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] DIV0_Q = DIV0_Q_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [2:0] LAST_CNT = 3'(DIV_ITER - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_sh;
  logic [2:0]       cnt;
  logic             dz_res;
  logic [WIDTH-1:0] step_r;
  logic             step_ge;
  logic             accept;

  eight_bit_divider_div_step u_step (
    .r      (r_reg),
    .a_msb  (a_reg[WIDTH-1]),
    .b      (b_reg),
    .r_next (step_r),
    .ge     (step_ge)
  );

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      q_sh      <= '0;
      cnt       <= '0;
      dz_res    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          a_reg <= a_reg << 1;
          r_reg <= step_r;
          q_sh  <= {q_sh[WIDTH-2:0], step_ge};
          cnt   <= cnt + 3'd1;
          if (cnt == LAST_CNT) begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          quotient  <= q_sh;
          remainder <= r_reg;
          div_zero  <= dz_res;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the case so a start in DONE overrides the return to IDLE.
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
        cnt   <= '0;
        if (in_b == '0) begin
          state  <= ST_DONE;
          busy   <= 1'b0;
          q_sh   <= DIV0_Q;
          r_reg  <= in_a;
          dz_res <= 1'b1;
        end
`ifdef EIGHT_BIT_DIVIDER_EARLY_EXIT_EN
        else if (in_a < in_b) begin
          state  <= ST_DONE;
          busy   <= 1'b0;
          q_sh   <= '0;
          r_reg  <= in_a;
          dz_res <= 1'b0;
        end
`endif
        else begin
          state  <= ST_RUN;
          busy   <= 1'b1;
          q_sh   <= '0;
          r_reg  <= '0;
          dz_res <= 1'b0;
        end
      end
    end
  end

endmodule
